// File: rtl/load_buffer_tracker.sv
// Outstanding-load tracker between the load unit and the data cache: allocates cache
// request IDs, remembers per-load formatting info, and returns aligned/extended results.
module load_buffer_tracker #(
    parameter int unsigned NR_ENTRIES = 2,
    parameter int unsigned IDX_W      = $clog2(NR_ENTRIES),
    parameter int unsigned TRANS_ID_W = 2,
    parameter int unsigned XLEN       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    input  logic [TRANS_ID_W-1:0] alloc_trans_id_i,
    input  logic [1:0]            alloc_offset_i,
    input  logic [1:0]            alloc_size_i,
    input  logic                  alloc_signed_i,
    output logic [IDX_W-1:0]      alloc_id_o,
    input  logic                  rsp_valid_i,
    input  logic [IDX_W-1:0]      rsp_id_i,
    input  logic [XLEN-1:0]       rsp_data_i,
    output logic                  result_valid_o,
    output logic [TRANS_ID_W-1:0] result_trans_id_o,
    output logic [XLEN-1:0]       result_data_o,
    output logic [IDX_W:0]        count_o,
    output logic                  empty_o,
    output logic                  spurious_o
);

    typedef enum logic [1:0] {StFree, StPending, StKilled} entry_state_e;

    entry_state_e          state_q [NR_ENTRIES];
    entry_state_e          state_d [NR_ENTRIES];
    logic [TRANS_ID_W-1:0] trans_q [NR_ENTRIES];
    logic [1:0]            offset_q [NR_ENTRIES];
    logic [1:0]            size_q [NR_ENTRIES];
    logic                  signed_q [NR_ENTRIES];

    logic                  result_valid_q;
    logic [TRANS_ID_W-1:0] result_trans_q;
    logic [XLEN-1:0]       result_data_q;
    logic                  spurious_q;

    logic                  any_free;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W:0]        occupied;
    logic                  alloc_fire;
    entry_state_e          rsp_state;
    logic                  rsp_hit;
    logic                  rsp_release;
    logic                  rsp_spurious;

    function automatic logic [XLEN-1:0] fmt_data(input logic [XLEN-1:0] data,
                                                 input logic [1:0] off,
                                                 input logic [1:0] size,
                                                 input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   fmt_data = {{(XLEN-8){sgn & b[7]}}, b};
            2'b01:   fmt_data = {{(XLEN-16){sgn & h[15]}}, h};
            default: fmt_data = data;
        endcase
    endfunction

    // Lowest-index free entry and occupancy, both from registered state only.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        occupied = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == StFree) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end else begin
                occupied = occupied + (IDX_W+1)'(1);
            end
        end
    end

    assign alloc_ready_o = any_free && !flush_i;
    assign alloc_id_o    = free_idx;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

    assign rsp_state    = state_q[rsp_id_i];
    assign rsp_hit      = rsp_valid_i && (rsp_state == StPending);
    assign rsp_release  = rsp_valid_i && (rsp_state != StFree);
    assign rsp_spurious = rsp_valid_i && (rsp_state == StFree);

    // Response beats flush for the same entry; allocation only targets a free entry.
    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            if (flush_i && state_q[i] == StPending) begin
                state_d[i] = StKilled;
            end
            if (rsp_release && rsp_id_i == IDX_W'(i)) begin
                state_d[i] = StFree;
            end
            if (alloc_fire && free_idx == IDX_W'(i)) begin
                state_d[i] = StPending;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                state_q[i] <= StFree;
            end
            result_valid_q <= 1'b0;
            result_trans_q <= '0;
            result_data_q  <= '0;
            spurious_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
            end
            result_valid_q <= rsp_hit;
            if (rsp_hit) begin
                result_trans_q <= trans_q[rsp_id_i];
                result_data_q  <= fmt_data(rsp_data_i, offset_q[rsp_id_i], size_q[rsp_id_i],
                                           signed_q[rsp_id_i]);
            end
            if (rsp_spurious) begin
                spurious_q <= 1'b1;
            end
        end
    end

    // Payload is only meaningful while the entry is occupied, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            trans_q[free_idx]  <= alloc_trans_id_i;
            offset_q[free_idx] <= alloc_offset_i;
            size_q[free_idx]   <= alloc_size_i;
            signed_q[free_idx] <= alloc_signed_i;
        end
    end

    assign result_valid_o    = result_valid_q;
    assign result_trans_id_o = result_trans_q;
    assign result_data_o     = result_data_q;
    assign count_o           = occupied;
    assign empty_o           = (occupied == '0);
    assign spurious_o        = spurious_q;

endmodule

// File: tb/tb_load_buffer_tracker.sv
// Bench for load_buffer_tracker: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a behavioural model of the entry table.
module tb_load_buffer_tracker;

    localparam int NR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [1:0]  alloc_trans;
    logic [1:0]  alloc_off;
    logic [1:0]  alloc_size;
    logic        alloc_sgn;
    logic        alloc_id;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        result_valid;
    logic [1:0]  result_trans;
    logic [31:0] result_data;
    logic [1:0]  count;
    logic        empty;
    logic        spurious;

    always #5 clk = ~clk;

    load_buffer_tracker dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .alloc_valid_i     (alloc_valid),
        .alloc_ready_o     (alloc_ready),
        .alloc_trans_id_i  (alloc_trans),
        .alloc_offset_i    (alloc_off),
        .alloc_size_i      (alloc_size),
        .alloc_signed_i    (alloc_sgn),
        .alloc_id_o        (alloc_id),
        .rsp_valid_i       (rsp_valid),
        .rsp_id_i          (rsp_id),
        .rsp_data_i        (rsp_data),
        .result_valid_o    (result_valid),
        .result_trans_id_o (result_trans),
        .result_data_o     (result_data),
        .count_o           (count),
        .empty_o           (empty),
        .spurious_o        (spurious)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = free, 1 = pending, 2 = killed.
    int          m_st [NR];
    logic [1:0]  m_trans [NR];
    logic [1:0]  m_off [NR];
    logic [1:0]  m_size [NR];
    logic        m_sgn [NR];
    logic        m_rv;
    logic [1:0]  m_rt;
    logic [31:0] m_rd;
    logic        m_spur;
    bit          seen_rst = 0;

    function automatic logic [31:0] model_fmt(input logic [31:0] d, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        int          sh;
        if (size == 2'd0) begin
            sh = 8 * int'(off);
            v  = (d >> sh) & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            sh = (off >= 2'd2) ? 16 : 0;
            v  = (d >> sh) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < NR; i++) if (m_st[i] == 0) return i;
        return -1;
    endfunction

    function automatic int occupied();
        int n = 0;
        for (int i = 0; i < NR; i++) if (m_st[i] != 0) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        int af;
        bit rdy;
        if (rst) begin
            for (int i = 0; i < NR; i++) m_st[i] = 0;
            m_rv = 0; m_rt = 0; m_rd = 0; m_spur = 0;
            seen_rst = 1;
        end else if (seen_rst) begin
            af  = first_free();
            rdy = (af >= 0) && !flush;
            m_rv = 0;
            if (rsp_valid) begin
                if (m_st[rsp_id] == 1) begin
                    m_rv = 1;
                    m_rt = m_trans[rsp_id];
                    m_rd = model_fmt(rsp_data, m_off[rsp_id], m_size[rsp_id], m_sgn[rsp_id]);
                    m_st[rsp_id] = 0;
                end else if (m_st[rsp_id] == 2) begin
                    m_st[rsp_id] = 0;
                end else begin
                    m_spur = 1;
                end
            end
            if (flush) for (int i = 0; i < NR; i++) if (m_st[i] == 1) m_st[i] = 2;
            if (alloc_valid && rdy) begin
                m_st[af]    = 1;
                m_trans[af] = alloc_trans;
                m_off[af]   = alloc_off;
                m_size[af]  = alloc_size;
                m_sgn[af]   = alloc_sgn;
            end
        end
    end

    always @(negedge clk) begin
        int ff;
        if (seen_rst) begin
            ff = first_free();
            check("ready", alloc_ready, (ff >= 0) && !flush);
            if (ff >= 0) check("alloc_id", alloc_id, ff);
            check("count", count, occupied());
            check("empty", empty, occupied() == 0);
            check("spurious", spurious, m_spur);
            check("result_valid", result_valid, m_rv);
            check("result_trans", result_trans, m_rt);
            check("result_data", result_data, m_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        flush = 0; alloc_valid = 0; rsp_valid = 0;
    endtask

    task automatic set_alloc(input logic [1:0] t, input logic [1:0] o, input logic [1:0] s,
                             input logic g);
        alloc_valid = 1; alloc_trans = t; alloc_off = o; alloc_size = s; alloc_sgn = g;
    endtask

    task automatic set_rsp(input logic id, input logic [31:0] d);
        rsp_valid = 1; rsp_id = id; rsp_data = d;
    endtask

    task automatic one_load(input string name, input logic [1:0] t, input logic [1:0] o,
                            input logic [1:0] s, input logic g, input logic [31:0] d,
                            input logic [31:0] exp);
        set_alloc(t, o, s, g);
        check({name, "_id"}, alloc_id, 0);
        tick(); clr();
        set_rsp(0, d);
        tick(); clr();
        check({name, "_valid"}, result_valid, 1);
        check({name, "_trans"}, result_trans, t);
        check({name, "_data"}, result_data, exp);
    endtask

    initial begin
        int occ [$];
        rst = 1; clr();
        alloc_trans = 0; alloc_off = 0; alloc_size = 0; alloc_sgn = 0;
        rsp_id = 0; rsp_data = 0;
        tick();
        rst = 0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_ready", alloc_ready, 1);
        check("rst_valid", result_valid, 0);
        check("rst_data", result_data, 0);
        check("rst_spur", spurious, 0);

        one_load("word", 2, 0, 2, 0, 32'h8000_00F0, 32'h8000_00F0);
        check("word_count", count, 0);
        one_load("byte_s", 1, 3, 0, 1, 32'h9A00_0000, 32'hFFFF_FF9A);
        one_load("byte_u", 1, 3, 0, 0, 32'h9A00_0000, 32'h0000_009A);
        one_load("half_s", 1, 2, 1, 1, 32'h9A00_0000, 32'hFFFF_9A00);
        tick();
        check("hold_data", result_data, 32'hFFFF_9A00);

        // Full, then out-of-order response: freed slot not reusable in the same cycle.
        set_alloc(0, 0, 2, 0); tick();
        set_alloc(1, 0, 2, 0); tick(); clr();
        check("full_ready", alloc_ready, 0);
        check("full_count", count, 2);
        set_rsp(1, 32'h1234_5678); #1;
        check("rsp_cycle_ready", alloc_ready, 0);
        tick(); clr();
        check("after_rsp_ready", alloc_ready, 1);
        check("after_rsp_id", alloc_id, 1);
        check("ooo_data", result_data, 32'h1234_5678);
        set_rsp(0, 0); tick(); clr();

        // Flush kills both; their responses are dropped.
        set_alloc(2, 0, 2, 0); tick();
        set_alloc(3, 0, 2, 0); tick(); clr();
        flush = 1; tick(); clr();
        check("kill_count", count, 2);
        set_rsp(0, 32'hDEAD_BEEF); tick(); clr();
        check("kill0_valid", result_valid, 0);
        set_rsp(1, 32'hDEAD_BEEF); tick(); clr();
        check("kill1_valid", result_valid, 0);
        check("kill_count0", count, 0);
        one_load("post_flush", 3, 1, 1, 0, 32'h0000_ABCD, 32'h0000_ABCD);

        // Flush with a same-cycle response: response wins, allocation ignored.
        set_alloc(0, 0, 2, 0); tick();
        set_alloc(1, 0, 2, 0); tick(); clr();
        set_rsp(0, 32'h5555_AAAA); flush = 1; set_alloc(2, 0, 2, 0); tick(); clr();
        check("fr_valid", result_valid, 1);
        check("fr_data", result_data, 32'h5555_AAAA);
        check("fr_count", count, 1);
        set_rsp(1, 32'h1); tick(); clr();
        check("fr_killed", result_valid, 0);

        // Spurious response is sticky until reset; reset drops pending loads.
        set_rsp(0, 32'h0); tick(); clr();
        check("spur_set", spurious, 1);
        set_alloc(0, 0, 2, 0); tick();
        set_alloc(1, 0, 2, 0); tick(); clr();
        check("spur_sticky", spurious, 1);
        rst = 1; tick(); rst = 0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_spur", spurious, 0);

        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(199) == 0);
            flush       = ($urandom_range(11) == 0);
            alloc_valid = $urandom_range(1);
            alloc_trans = 2'($urandom);
            alloc_off   = 2'($urandom);
            alloc_size  = 2'($urandom);
            alloc_sgn   = 1'($urandom);
            rsp_valid   = $urandom_range(1);
            rsp_data    = $urandom;
            occ.delete();
            for (int i = 0; i < NR; i++) if (m_st[i] != 0) occ.push_back(i);
            if (occ.size() > 0 && $urandom_range(9) != 0)
                rsp_id = 1'(occ[$urandom_range(occ.size() - 1)]);
            else
                rsp_id = 1'($urandom);
            tick();
        end
        rst = 0; clr();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
